vx_lsu_tex_arb: RTL
===================

VX_LSU_TEX_ARB -- requirements
Module: VX_lsu_tex_arb

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: thread lanes per request.
REQ-002 SHALL have parameter DATA_SIZE, default 4: bytes per lane word.
REQ-003 SHALL have parameter TAG_IN_WIDTH, default 8: requester tag width.
REQ-004 SHALL have parameter TAG_SEL_IDX, default 0: bit position where the requester-id bit is inserted into the outgoing tag.
REQ-005 SHALL have parameter PENDING_SIZE, default 16: maximum outstanding reads per requester.
REQ-006 SHALL have ports clk, in, 1, clock; and reset, in, 1, asynchronous active-low reset.
REQ-007 SHALL have ports req_valid_in, req_rw_in, req_ready_in (out), each 2 bits, one per requester (0=LSU, 1=TEX).
REQ-008 SHALL have ports req_byteen_in, req_addr_in, req_data_in and req_tag_in, in, 2x{NUM_LANES*DATA_SIZE, NUM_LANES*30, NUM_LANES*DATA_SIZE*8, TAG_IN_WIDTH}, plus a per-lane tmask in 2xNUM_LANES.
REQ-009 SHALL have ports req_valid_out, req_rw_out, req_tmask_out, req_byteen_out, req_addr_out, req_data_out and req_tag_out (TAG_IN_WIDTH+1), out; req_ready_out, in, 1.
REQ-010 SHALL have ports rsp_valid_in, rsp_tmask_in, rsp_data_in and rsp_tag_in (TAG_IN_WIDTH+1), in; rsp_ready_in, out.
REQ-011 SHALL have ports rsp_valid_out, rsp_tmask_out, rsp_data_out and rsp_tag_out (TAG_IN_WIDTH), out, 2 each; rsp_ready_out, in, 2.
REQ-012 SHALL have port busy, out, 1: an output request is buffered or a read is pending.

Function
REQ-013 Arbitration SHALL be round-robin between valid requesters; on a tie, priority goes to the requester not granted last; the pointer SHALL advance only on an input handshake.
REQ-014 A requester whose pending counter equals PENDING_SIZE SHALL NOT be granted read requests; its writes remain eligible.
REQ-015 The output SHALL be one register stage: req_ready_in[g] = grant[g] && (!req_valid_out || req_ready_out); the request SHALL appear on outputs the cycle after the handshake (latency 1, full throughput).
REQ-016 Output payload SHALL hold stable while req_valid_out && !req_ready_out.
REQ-017 req_tag_out SHALL equal req_tag_in[g] with bit g inserted at TAG_SEL_IDX; lower bits are unshifted and upper bits are shifted up by one.
REQ-018 The response path SHALL be combinational: the id bit at TAG_SEL_IDX of rsp_tag_in selects the target; rsp_tag_out is the tag with that bit removed; rsp_ready_in = rsp_ready_out[id]; the other requester's rsp_valid_out SHALL be 0.
REQ-019 Pending counter[i] SHALL +1 on an accepted read from i and -1 on a response handshake to i; simultaneous events SHALL leave it unchanged.
REQ-020 A response to a requester whose counter is 0, or an increment at PENDING_SIZE, SHALL fire a simulation assertion; the counter SHALL NOT wrap.
REQ-021 Writes SHALL NOT touch the counters and no response is expected for them.
REQ-022 busy = req_valid_out || (counter[0] != 0) || (counter[1] != 0).

Reset
REQ-023 On reset assertion, req_valid_out, both counters, the round-robin pointer (to prefer requester 0) and busy SHALL clear asynchronously; the payload registers need no reset.
REQ-024 A request buffered when reset asserts SHALL be dropped; after deassertion the first grant with both valid SHALL go to requester 0.

Structure
REQ-025 Requester ids (LSU=0, TEX=1), the request-address-width constant and the tag insert/remove width rule SHALL live in the shared VX_gpu_pkg.
REQ-026 The round-robin grant logic SHALL be a sub-module VX_rr_arbiter (NUM_REQS=2, with a grant-unlock input); the counters and output stage stay inline.

Verification
REQ-027 Both valid on every cycle, req_ready_out=1 -> grants alternate 0,1,0,1; one output per cycle; tags 0xA5 (LSU) -> 0x14A, 0xA5 (TEX) -> 0x14B, with TAG_SEL_IDX=0.
REQ-028 req_ready_out held 0 for 5 cycles with a TEX request buffered -> outputs stable; req_ready_in=0; the request drains on the first ready cycle.
REQ-029 LSU issues 16 reads with no responses -> the 17th LSU read is stalled, LSU writes and TEX reads still pass; one response to LSU -> the stalled read is accepted the next cycle.
REQ-030 rsp_tag_in=0x14B, rsp_ready_out=2'b01 -> rsp_valid_out=2'b10, rsp_tag_out[1]=0xA5, rsp_ready_in=0; no counter change until TEX ready.
REQ-031 Accepted read and response for the same requester in one cycle -> counter unchanged; busy stays 1 while the counter is nonzero.
REQ-032 Reset asserted mid-stall with req_valid_out=1 and counters 3/2 -> all clear within the same cycle; busy=0; the first post-reset contention grants LSU.

Source files
------------

// File: rtl/vx_lsu_tex_arb_pkg.sv
// Shared GPU definitions: requester ids, request address width and the tag width rule
// used when a requester-id bit is inserted into (or removed from) a memory tag.
package VX_gpu_pkg;

    typedef enum logic {
        REQ_LSU = 1'b0,
        REQ_TEX = 1'b1
    } req_id_e;

    localparam int NUM_REQUESTERS = 2;
    localparam int REQ_ADDR_WIDTH = 30;

    // One id bit is spliced into the tag on the way out and stripped on the way back.
    function automatic int tag_out_width(input int tagInWidth);
        return tagInWidth + 1;
    endfunction

endpackage

// File: rtl/vx_lsu_tex_arb_rr_arbiter.sv
// Round-robin grant logic; the last-granted pointer only moves when the caller
// reports that the current grant was actually taken (unlock).
module VX_rr_arbiter #(
    parameter int NUM_REQS = 2,
    localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQS-1:0] requests_i,
    input  logic                unlock_i,
    output logic [NUM_REQS-1:0] grant_onehot_o,
    output logic [IDX_W-1:0]    grant_index_o,
    output logic                grant_valid_o
);

    logic [IDX_W-1:0] lastQ;
    logic [IDX_W-1:0] lastD;
    logic             found;
    int               candIdx;

    // Search starts just after the last winner, so the other requester wins a tie.
    always_comb begin
        grant_onehot_o = '0;
        grant_index_o  = '0;
        found          = 1'b0;
        candIdx        = 0;
        for (int i = 1; i <= NUM_REQS; i++) begin
            candIdx = (int'(lastQ) + i) % NUM_REQS;
            if (!found && requests_i[candIdx]) begin
                found                   = 1'b1;
                grant_onehot_o[candIdx] = 1'b1;
                grant_index_o           = IDX_W'(candIdx);
            end
        end
    end

    assign grant_valid_o = |requests_i;

    always_comb begin
        lastD = lastQ;
        if (unlock_i && grant_valid_o) begin
            lastD = grant_index_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastQ <= IDX_W'(NUM_REQS - 1);
        end else begin
            lastQ <= lastD;
        end
    end

endmodule

// File: rtl/vx_lsu_tex_arb.sv
// Merges LSU and TEX memory requests onto one registered port, tags each with its
// requester id, routes responses back by that id and bounds outstanding reads.
import VX_gpu_pkg::*;

module vx_lsu_tex_arb #(
    parameter int NUM_LANES    = 4,
    parameter int DATA_SIZE    = 4,
    parameter int TAG_IN_WIDTH = 8,
    parameter int TAG_SEL_IDX  = 0,
    parameter int PENDING_SIZE = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,

    input  logic [1:0]                             req_valid_in,
    input  logic [1:0]                             req_rw_in,
    output logic [1:0]                             req_ready_in,
    input  logic [2*NUM_LANES-1:0]                 req_tmask_in,
    input  logic [2*NUM_LANES*DATA_SIZE-1:0]       req_byteen_in,
    input  logic [2*NUM_LANES*REQ_ADDR_WIDTH-1:0]  req_addr_in,
    input  logic [2*NUM_LANES*DATA_SIZE*8-1:0]     req_data_in,
    input  logic [2*TAG_IN_WIDTH-1:0]              req_tag_in,

    output logic                                   req_valid_out,
    output logic                                   req_rw_out,
    output logic [NUM_LANES-1:0]                   req_tmask_out,
    output logic [NUM_LANES*DATA_SIZE-1:0]         req_byteen_out,
    output logic [NUM_LANES*REQ_ADDR_WIDTH-1:0]    req_addr_out,
    output logic [NUM_LANES*DATA_SIZE*8-1:0]       req_data_out,
    output logic [TAG_IN_WIDTH:0]                  req_tag_out,
    input  logic                                   req_ready_out,

    input  logic                                   rsp_valid_in,
    input  logic [NUM_LANES-1:0]                   rsp_tmask_in,
    input  logic [NUM_LANES*DATA_SIZE*8-1:0]       rsp_data_in,
    input  logic [TAG_IN_WIDTH:0]                  rsp_tag_in,
    output logic                                   rsp_ready_in,

    output logic [1:0]                             rsp_valid_out,
    output logic [2*NUM_LANES-1:0]                 rsp_tmask_out,
    output logic [2*NUM_LANES*DATA_SIZE*8-1:0]     rsp_data_out,
    output logic [2*TAG_IN_WIDTH-1:0]              rsp_tag_out,
    input  logic [1:0]                             rsp_ready_out,

    output logic                                   busy
);

    localparam int BE_W      = NUM_LANES * DATA_SIZE;
    localparam int ADDR_W    = NUM_LANES * REQ_ADDR_WIDTH;
    localparam int DATA_W    = NUM_LANES * DATA_SIZE * 8;
    localparam int TAG_OUT_W = tag_out_width(TAG_IN_WIDTH);
    localparam int CNT_W     = $clog2(PENDING_SIZE + 1);

    localparam logic [CNT_W-1:0] PENDING_MAX = CNT_W'(PENDING_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [1:0]              eligible;
    logic [1:0]              grantOnehot;
    logic                    grantIdx;
    logic                    grantValid;
    logic                    canAccept;
    logic                    fire;

    logic                    selRw;
    logic [NUM_LANES-1:0]    selTmask;
    logic [BE_W-1:0]         selByteen;
    logic [ADDR_W-1:0]       selAddr;
    logic [DATA_W-1:0]       selData;
    logic [TAG_IN_WIDTH-1:0] selTag;
    logic [TAG_OUT_W-1:0]    tagD;

    logic                    validQ;
    logic                    validD;
    logic                    rwQ;
    logic [NUM_LANES-1:0]    tmaskQ;
    logic [BE_W-1:0]         byteenQ;
    logic [ADDR_W-1:0]       addrQ;
    logic [DATA_W-1:0]       dataQ;
    logic [TAG_OUT_W-1:0]    tagQ;

    logic [1:0][CNT_W-1:0]   pendingQ;
    logic [1:0][CNT_W-1:0]   pendingD;
    logic [1:0]              incr;
    logic [1:0]              decr;

    req_id_e                 rspId;
    logic [TAG_IN_WIDTH-1:0] rspTagStripped;

    // Reads are held back once a requester has PENDING_SIZE of them in flight.
    always_comb begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            eligible[i] = req_valid_in[i] && (req_rw_in[i] || (pendingQ[i] != PENDING_MAX));
        end
    end

    VX_rr_arbiter #(
        .NUM_REQS (NUM_REQUESTERS)
    ) rrArbiter (
        .clk            (clk),
        .rst_n          (rst_n),
        .requests_i     (eligible),
        .unlock_i       (canAccept),
        .grant_onehot_o (grantOnehot),
        .grant_index_o  (grantIdx),
        .grant_valid_o  (grantValid)
    );

    assign canAccept    = !validQ || req_ready_out;
    assign fire         = grantValid && canAccept;
    assign req_ready_in = grantOnehot & {2{canAccept}};

    assign selRw     = grantIdx ? req_rw_in[1]                        : req_rw_in[0];
    assign selTmask  = grantIdx ? req_tmask_in[2*NUM_LANES-1:NUM_LANES] : req_tmask_in[NUM_LANES-1:0];
    assign selByteen = grantIdx ? req_byteen_in[2*BE_W-1:BE_W]         : req_byteen_in[BE_W-1:0];
    assign selAddr   = grantIdx ? req_addr_in[2*ADDR_W-1:ADDR_W]       : req_addr_in[ADDR_W-1:0];
    assign selData   = grantIdx ? req_data_in[2*DATA_W-1:DATA_W]       : req_data_in[DATA_W-1:0];
    assign selTag    = grantIdx ? req_tag_in[2*TAG_IN_WIDTH-1:TAG_IN_WIDTH] : req_tag_in[TAG_IN_WIDTH-1:0];

    generate
        if (TAG_SEL_IDX == 0) begin : gTagLow
            assign tagD           = {selTag, grantIdx};
            assign rspTagStripped = rsp_tag_in[TAG_IN_WIDTH:1];
        end else if (TAG_SEL_IDX == TAG_IN_WIDTH) begin : gTagHigh
            assign tagD           = {grantIdx, selTag};
            assign rspTagStripped = rsp_tag_in[TAG_IN_WIDTH-1:0];
        end else begin : gTagMid
            assign tagD           = {selTag[TAG_IN_WIDTH-1:TAG_SEL_IDX], grantIdx,
                                     selTag[TAG_SEL_IDX-1:0]};
            assign rspTagStripped = {rsp_tag_in[TAG_IN_WIDTH:TAG_SEL_IDX+1],
                                     rsp_tag_in[TAG_SEL_IDX-1:0]};
        end
    endgenerate

    always_comb begin
        validD = validQ;
        if (fire) begin
            validD = 1'b1;
        end else if (req_ready_out) begin
            validD = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validQ <= 1'b0;
        end else begin
            validQ <= validD;
        end
    end

    // Payload only loads on a handshake, which keeps it stable under backpressure.
    always_ff @(posedge clk) begin
        if (fire) begin
            rwQ     <= selRw;
            tmaskQ  <= selTmask;
            byteenQ <= selByteen;
            addrQ   <= selAddr;
            dataQ   <= selData;
            tagQ    <= tagD;
        end
    end

    assign req_valid_out  = validQ;
    assign req_rw_out     = rwQ;
    assign req_tmask_out  = tmaskQ;
    assign req_byteen_out = byteenQ;
    assign req_addr_out   = addrQ;
    assign req_data_out   = dataQ;
    assign req_tag_out    = tagQ;

    assign rspId         = req_id_e'(rsp_tag_in[TAG_SEL_IDX]);
    assign rsp_ready_in  = rsp_ready_out[rsp_tag_in[TAG_SEL_IDX]];
    assign rsp_valid_out = {rsp_valid_in && (rspId == REQ_TEX), rsp_valid_in && (rspId == REQ_LSU)};
    assign rsp_tmask_out = {2{rsp_tmask_in}};
    assign rsp_data_out  = {2{rsp_data_in}};
    assign rsp_tag_out   = {2{rspTagStripped}};

    always_comb begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            incr[i] = fire && grantOnehot[i] && !req_rw_in[i];
            decr[i] = rsp_valid_in && rsp_ready_in && (rsp_tag_in[TAG_SEL_IDX] == 1'(i));
        end
    end

    // A read issued and a response returned in the same cycle cancel out.
    always_comb begin
        pendingD = pendingQ;
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (incr[i] && !decr[i] && (pendingQ[i] != PENDING_MAX)) begin
                pendingD[i] = pendingQ[i] + CNT_ONE;
            end else if (decr[i] && !incr[i] && (pendingQ[i] != '0)) begin
                pendingD[i] = pendingQ[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendingQ <= '0;
        end else begin
            pendingQ <= pendingD;
        end
    end

    assign busy = validQ || (pendingQ[0] != '0) || (pendingQ[1] != '0);

    generate
        for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : gPendingChecks
            assert property (@(posedge clk) disable iff (!rst_n) decr[g] |-> (pendingQ[g] != '0));
            assert property (@(posedge clk) disable iff (!rst_n) incr[g] |-> (pendingQ[g] != PENDING_MAX));
        end
    endgenerate

endmodule
